// File: rtl/int2flt_seq.sv
// -----------------------------------------------------------------------------
// int2flt_seq
//   Iterative converter from a 16-bit two's-complement integer to an IEEE-754
//   binary16 value. The magnitude is normalised one bit per clock, then rounded
//   and packed. The result is held on flt_o until the next conversion completes,
//   or until reset clears it.
//
// Parameters
//   BIAS     exponent bias (only 15 is meaningful for binary16)
//   RNE      1 = round-to-nearest-even, 0 = truncate
//
// Ports
//   clk_i    in   1   clock, rising edge
//   reset_i  in   1   synchronous, active-high reset
//   start_i  in   1   conversion request, honoured only when idle
//   int_i    in   16  two's-complement operand, captured on the accepting edge
//   flt_o    out  16  {sign, exp[4:0], mant[9:0]}, holds the last result
//   busy_o   out  1   high while a conversion is in progress (state != IDLE)
//   done_o   out  1   one-cycle pulse, flt_o valid from this cycle on
// -----------------------------------------------------------------------------
module int2flt_seq #(
  parameter int BIAS = 15,
  parameter bit RNE  = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] int_i,
  output logic [15:0] flt_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q,  sign_d;
  logic [15:0] mag_q,   mag_d;
  logic [4:0]  exp_q,   exp_d;
  logic [15:0] flt_q,   flt_d;

  // Round the normalised magnitude (bit 15 set) to 10 fraction bits and pack.
  // A carry out of the fraction bumps the exponent; with a 16-bit input the
  // exponent can never exceed 30, so no overflow to infinity is possible.
  function automatic logic [15:0] round_pack(input logic        sign,
                                             input logic [4:0]  exp,
                                             input logic [15:0] mag);
    logic [9:0]  mant;
    logic        guard;
    logic        sticky;
    logic        up;
    logic [10:0] sum;
    logic [4:0]  exp_r;
    mant   = mag[14:5];
    guard  = mag[4];
    sticky = |mag[3:0];
    up     = RNE && guard && (sticky || mant[0]);
    sum    = {1'b0, mant} + {10'd0, up};
    exp_r  = exp;
    if (sum[10]) begin
      exp_r = exp + 5'd1;
    end
    return {sign, exp_r, sum[9:0]};
  endfunction

  // Magnitude of a 16-bit two's-complement value; 0x8000 maps to 0x8000,
  // which is still correct when read as unsigned.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= 16'd0;
      exp_q   <= 5'd0;
      flt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      flt_q   <= flt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (int_i == 16'd0) ? S_DONE : S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q[15]) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    exp_d  = exp_q;
    flt_d  = flt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sign_d = int_i[15];
          mag_d  = abs16(int_i);
          exp_d  = 5'(BIAS + 15);
          // Zero skips normalisation entirely and always yields +0.
          if (int_i == 16'd0) begin
            flt_d = 16'd0;
          end
        end
      end
      S_NORM: begin
        if (!mag_q[15]) begin
          mag_d = {mag_q[14:0], 1'b0};
          exp_d = exp_q - 5'd1;
        end
      end
      S_ROUND: begin
        flt_d = round_pack(sign_q, exp_q, mag_q);
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    flt_o  = flt_q;
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_int2flt_seq.sv
module tb_int2flt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [15:0] flt_a, flt_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  always #5 clk = ~clk;

  // Round-to-nearest-even instance and truncating instance, driven in lockstep.
  int2flt_seq #(.BIAS(15), .RNE(1'b1)) dut_rne (
    .clk_i(clk), .reset_i(rst), .start_i(start), .int_i(din),
    .flt_o(flt_a), .busy_o(busy_a), .done_o(done_a)
  );

  int2flt_seq #(.BIAS(15), .RNE(1'b0)) dut_trn (
    .clk_i(clk), .reset_i(rst), .start_i(start), .int_i(din),
    .flt_o(flt_b), .busy_o(busy_b), .done_o(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp_rne;
    logic [15:0] exp_trn;
  } sb_t;

  sb_t sbq[$];
  sb_t cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference conversion: locate the leading one, then round the bits below
  // the 11-bit significand by comparing the remainder against one half.
  function automatic logic [15:0] model(input logic [15:0] x, input bit rne);
    int v, mag, p, r, m, rem, half, e;
    logic s;
    v = int'($signed(x));
    if (v == 0) return 16'h0000;
    s   = (v < 0);
    mag = s ? -v : v;
    p   = 0;
    for (int i = 0; i < 17; i++) if (((mag >> i) & 1) != 0) p = i;
    e = 15 + p;
    if (p <= 10) begin
      m = mag << (10 - p);
    end else begin
      r    = p - 10;
      m    = mag >> r;
      rem  = mag & ((1 << r) - 1);
      half = 1 << (r - 1);
      if (rne && (rem > half || (rem == half && (m & 1) != 0))) m++;
      if (m == 2048) begin
        m = 1024;
        e++;
      end
    end
    return {s, 5'(e), 10'(m & 1023)};
  endfunction

  // Half-to-integer, standing in for the downstream float-to-int stage.
  function automatic int flt2int(input logic [15:0] f);
    int e, val;
    e = int'(f[14:10]);
    if (e == 0) return 0;
    val = 1024 + int'(f[9:0]);
    if (e >= 25) val = val << (e - 25);
    else         val = val >> (25 - e);
    return f[15] ? -val : val;
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done_a || done_b) begin
      n_done++;
      chk("done_lockstep", {30'd0, done_a, done_b}, 32'd3);
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        cur = sbq.pop_front();
        chk("flt_rne", {16'd0, flt_a}, {16'd0, cur.exp_rne});
        chk("flt_trunc", {16'd0, flt_b}, {16'd0, cur.exp_trn});
        if ($signed(cur.x) >= -2048 && $signed(cur.x) <= 2048)
          chk("roundtrip", 32'(flt2int(flt_a)), 32'(int'($signed(cur.x))));
      end
    end
  end

  task automatic wait_done(input int lat_start, input int exp_lat);
    int lat;
    lat = lat_start;
    while (!done_a && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_a) begin
      chk("timeout", 32'd1, 32'd0);
    end else begin
      if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done_a}, 32'd0);
      chk("idle_after", {31'd0, busy_a}, 32'd0);
    end
  endtask

  // Latency is counted in edges after the accepting edge at which done_o is
  // first seen high; zero goes straight to DONE on the accepting edge itself.
  task automatic run_conv(input logic [15:0] x, input int exp_lat);
    din   = x;
    start = 1'b1;
    sbq.push_back('{x, model(x, 1'b1), model(x, 1'b0)});
    @(posedge clk); #1;
    start = 1'b0;
    din   = 16'($urandom);
    chk("busy_after_accept", {31'd0, busy_a}, 32'd1);
    wait_done(0, exp_lat);
  endtask

  int done_before;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    din   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flt",  {16'd0, flt_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv(16'h0001, 17);
    chk("one_value", {16'd0, flt_a}, 32'h3C00);
    run_conv(16'h8000, 2);
    chk("min_value", {16'd0, flt_a}, 32'hF800);
    run_conv(16'h7FFF, 3);
    chk("max_value", {16'd0, flt_a}, 32'h7800);
    run_conv(16'h0801, -1);
    chk("tie_even", {16'd0, flt_a}, 32'h6800);
    run_conv(16'h0803, -1);
    chk("tie_up", {16'd0, flt_a}, 32'h6802);
    chk("tie_trunc", {16'd0, flt_b}, 32'h6801);
    run_conv(16'h0000, 0);
    chk("zero_value", {16'd0, flt_a}, 32'h0000);
    run_conv(16'hFFFB, 15);
    chk("neg5_value", {16'd0, flt_a}, 32'hC500);

    // Abort a conversion with reset three cycles after it was accepted.
    din   = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_flt",  {16'd0, flt_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    done_before = n_done;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done), 32'(done_before));
    run_conv(16'h0001, 17);
    chk("after_abort", {16'd0, flt_a}, 32'h3C00);

    // start_i held high with a different operand while busy must be ignored.
    done_before = n_done;
    din   = 16'h0001;
    start = 1'b1;
    sbq.push_back('{16'h0001, model(16'h0001, 1'b1), model(16'h0001, 1'b0)});
    @(posedge clk); #1;
    din = 16'h1234;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(10, 17);
    repeat (25) @(posedge clk);
    #1;
    chk("busy_ignore_one_done", 32'(n_done - done_before), 32'd1);
    chk("busy_ignore_flt", {16'd0, flt_a}, 32'h3C00);

    for (int i = 0; i < 20; i++) begin
      run_conv(16'($urandom), -1);
    end
    for (int i = 0; i < 6; i++) begin
      run_conv(16'($urandom_range(0, 4096) - 2048), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
